// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the request, response and data-memory signals of the load/store
// unit.
//
//   master : requester / memory side (drives requests and mem_rdata)
//   slave  : the load_store_unit itself
//
// Signals
//   req_valid/req_ready            request handshake
//   req_write, req_funct3          store flag and RV32I size/sign code
//   req_addr, req_wdata            byte address and store data
//   resp_valid                     one-cycle completion pulse
//   resp_rdata, resp_misaligned    load result / rejection flag
//   mem_read, mem_write            word memory strobes
//   mem_addr, mem_wdata            word-aligned address and write word
//   mem_rdata                      combinational read data from memory
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Translates RV32I loads/stores into accesses on a word-wide data memory.
// Sub-word loads are lane-selected and extended; sub-word stores use a
// read-modify-write (MERGE then WRITE) because the memory writes whole words.
// Misaligned or illegal requests are answered with resp_misaligned and never
// touch memory.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    load_store_unit_if.slave: request handshake, response and
//          data-memory signals
// ---------------------------------------------------------------------------
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] merge_q;
    logic [31:0] resp_rdata_q;
    logic        resp_mis_q;
    logic        req_err;

    // Size legality differs between loads and stores; alignment is shared.
    function automatic logic is_illegal(input logic write, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad_size;
        logic bad_align;
        if (write)
            bad_size = f3[2] | (f3[1:0] == 2'b11);
        else
            bad_size = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        bad_align = ((f3[1:0] == 2'b01) & a[0]) |
                    ((f3[1:0] == 2'b10) & (a != 2'b00));
        return bad_size | bad_align;
    endfunction

    // Halfwords are aligned here, so shifting by a*8 equals shifting by a[1]*16.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
        logic [31:0]        lane;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        r;
        lane   = word >> {a, 3'b000};
        byte_s = signed'(lane[7:0]);
        half_s = signed'(lane[15:0]);
        case (f3)
            3'b000:  r = 32'(byte_s);
            3'b001:  r = 32'(half_s);
            3'b100:  r = {24'h0, lane[7:0]};
            3'b101:  r = {16'h0, lane[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  a);
        logic [31:0] mask;
        logic [4:0]  sh;
        sh   = {a, 3'b000};
        mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    assign req_err = is_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!bus.req_write)
                        state_next = LOAD;
                    else if (bus.req_funct3[1:0] == 2'b10)
                        state_next = WRITE;
                    else
                        state_next = MERGE;
                end
            end
            LOAD:    state_next = RESP;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_write is gated by reset so an abandoned store never commits.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            LOAD, MERGE: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {addr_q[31:2], 2'b00};
            end
            WRITE: begin
                bus.mem_write = !reset;
                bus.mem_addr  = {addr_q[31:2], 2'b00};
                bus.mem_wdata = merge_q;
            end
            RESP:    bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch, load result and merge word.
    always_ff @(posedge clk) begin
        if (reset) begin
            merge_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_mis_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q     <= bus.req_addr;
                        funct3_q   <= bus.req_funct3;
                        wdata_q    <= bus.req_wdata;
                        resp_mis_q <= req_err;
                        if (req_err || bus.req_write)
                            resp_rdata_q <= 32'h0;
                        // SW writes this directly; SB/SH overwrite it in MERGE.
                        if (bus.req_write)
                            merge_q <= bus.req_wdata;
                    end
                end
                LOAD:  resp_rdata_q <= load_extend(bus.mem_rdata, funct3_q, addr_q[1:0]);
                MERGE: merge_q <= merge_lane(bus.mem_rdata, wdata_q, funct3_q[1:0], addr_q[1:0]);
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int resp_pulses = 0;

    // Word memory (64 words, bytes 0x00..0xFF) and the reference image.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en   = 1'b0;
    logic [5:0]  pl_idx  = 6'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (bus.mem_write === 1'b1)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = (bus.mem_addr < 32'd256) ? mem[bus.mem_addr[7:2]] : 32'h0;

    always @(negedge clk) if (bus.resp_valid === 1'b1) resp_pulses++;

    // ---------------- reference model ----------------
    function automatic bit ref_err(input bit w, input int f3, input int a);
        if (w)
            return (f3 > 2) || (f3 == 1 && a % 2 != 0) || (f3 == 2 && a % 4 != 0);
        return (f3 == 3 || f3 == 6 || f3 == 7) ||
               ((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int f3, input int a);
        int unsigned sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = 8 * (a % 4);
        b = (w >> sh) & 32'hFF;
        h = (w >> sh) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int f3, input int a,
                                              input logic [31:0] wd);
        logic [31:0] r;
        int n;
        r = w;
        n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        for (int i = 0; i < n; i++)
            r[(a % 4 + i) * 8 +: 8] = wd[i * 8 +: 8];
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'(idx); pl_data = v;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Issues one request; returns latency in cycles from the accept edge
    // (0 = no response, -1 = never accepted) and what was seen on the way.
    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep,
                          output int lat, output logic [31:0] rd, output bit mis,
                          output bit saw_rd, output bit saw_wr, output bit both,
                          output bit rdy_busy);
        int n;
        lat = 0; rd = '0; mis = 0; saw_rd = 0; saw_wr = 0; both = 0; rdy_busy = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            saw_rd |= (bus.mem_read === 1'b1);
            saw_wr |= (bus.mem_write === 1'b1);
            both   |= (bus.mem_read === 1'b1 && bus.mem_write === 1'b1);
            rdy_busy |= (bus.req_ready === 1'b1);
            if (bus.resp_valid === 1'b1) begin
                lat = k; rd = bus.resp_rdata; mis = bus.resp_misaligned;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
        checks++; if (bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b want 0", bus.resp_misaligned); end
        checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00 || bus.mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem_side got rd=%b wr=%b addr=%h want 0", bus.mem_read, bus.mem_write, bus.mem_addr); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd; bit mis, sr, sw, bz, rb;
        preload(4, 32'h8899AABB);
        do_req(0, 3'b000, 32'h11, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_rdata got %h want ffffffaa", rd); end
        do_req(0, 3'b100, 32'h11, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu_rdata got %h want 000000aa", rd); end
        do_req(0, 3'b001, 32'h12, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL lh_rdata got %h want ffff8899", rd); end
        do_req(0, 3'b101, 32'h12, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (rd !== 32'h00008899) begin errors++; $display("FAIL lhu_rdata got %h want 00008899", rd); end
        do_req(0, 3'b010, 32'h10, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata got %h want 8899aabb", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++; if (sr !== 1'b1 || sw !== 1'b0 || bz !== 1'b0 || mis !== 1'b0) begin
            errors++; $display("FAIL lw_strobes got rd=%b wr=%b both=%b mis=%b want 1 0 0 0", sr, sw, bz, mis); end
    endtask

    task automatic test_stores();
        int lat; logic [31:0] rd; bit mis, sr, sw, bz, rb;
        preload(4, 32'h8899AABB);
        do_req(1, 3'b000, 32'h13, 32'h12345677, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (mem[4] !== 32'h7799AABB) begin errors++; $display("FAIL sb_word got %h want 7799aabb", mem[4]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h0 || mis !== 1'b0 || sr !== 1'b1) begin
            errors++; $display("FAIL sb_resp got rdata=%h mis=%b rd=%b want 0 0 1", rd, mis, sr); end
        preload(4, 32'h8899AABB);
        do_req(1, 3'b001, 32'h12, 32'h0000CAFE, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (mem[4] !== 32'hCAFEAABB) begin errors++; $display("FAIL sh_word got %h want cafeaabb", mem[4]); end
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, lat, rd, mis, sr, sw, bz, rb);
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word got %h want deadbeef", mem[4]); end
        checks++; if (sr !== 1'b0 || sw !== 1'b1 || lat !== 2 || bz !== 1'b0) begin
            errors++; $display("FAIL sw_strobes got rd=%b wr=%b lat=%0d want 0 1 2", sr, sw, lat); end
        ref_mem[4] = 32'hDEADBEEF;
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; bit mis, sr, sw, bz, rb;
        bit        tw [4] = '{0, 1, 0, 1};
        logic [2:0] tf [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] ta [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
        preload(4, 32'h13572468);
        for (int i = 0; i < 4; i++) begin
            // a good load first so the cleared rdata is observable
            do_req(0, 3'b010, 32'h10, 32'h0, 0, lat, rd, mis, sr, sw, bz, rb);
            do_req(tw[i], tf[i], ta[i], 32'hFFFFFFFF, 0, lat, rd, mis, sr, sw, bz, rb);
            checks++; if (mis !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
                errors++; $display("FAIL err%0d_resp got mis=%b lat=%0d rdata=%h want 1 1 0", i, mis, lat, rd); end
            checks++; if (sr !== 1'b0 || sw !== 1'b0 || mem[4] !== 32'h13572468) begin
                errors++; $display("FAIL err%0d_mem got rd=%b wr=%b word=%h want 0 0 13572468", i, sr, sw, mem[4]); end
        end
    endtask

    task automatic test_reset_mid_write();
        int p0; int n;
        preload(4, 32'h8899AABB);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h00000055;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        p0 = resp_pulses;
        @(posedge clk); #1;          // MERGE
        bus.req_valid = 1'b0;
        @(posedge clk); #1;          // WRITE
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_write_gate got %b want 0", bus.mem_write); end
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL rst_word got %h want 8899aabb", mem[4]); end
        checks++; if (resp_pulses != p0) begin errors++; $display("FAIL rst_no_resp got %0d want 0 pulses", resp_pulses - p0); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; bit mis, sr, sw, bz, rb;
        int p0; logic [31:0] wd; logic [31:0] exp_rd;
        preload(8, 32'h0BADF00D);
        p0 = resp_pulses;
        exp_rd = 32'h0;
        for (int i = 0; i < 9; i++) begin
            wd = $urandom;
            if (i % 2 == 0) begin
                exp_rd = ref_mem[8];
                do_req(0, 3'b010, 32'h20, wd, 1, lat, rd, mis, sr, sw, bz, rb);
            end else begin
                exp_rd = 32'h0;
                ref_mem[8] = wd;
                do_req(1, 3'b010, 32'h20, wd, 1, lat, rd, mis, sr, sw, bz, rb);
            end
            checks++; if (rd !== exp_rd || lat !== 2 || rb !== 1'b0) begin
                errors++; $display("FAIL b2b%0d got rdata=%h lat=%0d busy_ready=%b want %h 2 0", i, rd, lat, rb, exp_rd); end
        end
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (resp_pulses - p0 != 9) begin errors++; $display("FAIL b2b_pulses got %0d want 9", resp_pulses - p0); end
        checks++; if (bus.resp_rdata !== exp_rd) begin errors++; $display("FAIL b2b_hold got %h want %h", bus.resp_rdata, exp_rd); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; bit mis, sr, sw, bz, rb;
        int f3, a, idx, exp_lat; bit w, e; logic [31:0] wd, exp_rd; bit exp_sr, exp_sw;
        int bad;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1)); f3 = $urandom_range(0, 7);
            a = $urandom_range(0, 255); wd = $urandom; idx = a / 4;
            e = ref_err(w, f3, a);
            exp_rd = 32'h0; exp_sr = 0; exp_sw = 0;
            if (e) exp_lat = 1;
            else if (!w) begin
                exp_lat = 2; exp_sr = 1; exp_rd = ref_load(ref_mem[idx], f3, a);
            end else begin
                exp_lat = (f3 == 2) ? 2 : 3; exp_sw = 1; exp_sr = (f3 != 2);
                ref_mem[idx] = ref_store(ref_mem[idx], f3, a, wd);
            end
            do_req(w, 3'(f3), 32'(a), wd, 0, lat, rd, mis, sr, sw, bz, rb);
            checks++; if (lat !== exp_lat || mis !== e) begin
                errors++; $display("FAIL rnd%0d_timing w=%0d f3=%0d a=%h got lat=%0d mis=%b want %0d %b", i, w, f3, a, lat, mis, exp_lat, e); end
            checks++; if (rd !== exp_rd) begin
                errors++; $display("FAIL rnd%0d_rdata w=%0d f3=%0d a=%h got %h want %h", i, w, f3, a, rd, exp_rd); end
            checks++; if (sr !== exp_sr || sw !== exp_sw || bz !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_strobes got rd=%b wr=%b both=%b want %b %b 0", i, sr, sw, bz, exp_sr, exp_sw); end
            checks++; if (mem[idx] !== ref_mem[idx]) begin
                errors++; $display("FAIL rnd%0d_word got %h want %h", i, mem[idx], ref_mem[idx]); end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mem_image got %0d differing words want 0", bad); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-addressed data memory, translating RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-wide memory accesses. Sub-word loads get byte-lane extraction and sign/zero extension. Sub-word stores use a read-modify-write sequence, because the memory only writes whole 32-bit words. Misaligned or illegal requests are rejected without touching memory.

## Interface

- No parameters; address and data are fixed at 32 bits.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits are used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (extended); 0 for stores and errors
- resp_misaligned  out  1  request rejected; valid with resp_valid
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data from memory

## Operation

- **States:** IDLE, LOAD, MERGE, WRITE, RESP.
- **IDLE:**
  - req_ready=1.
  - When req_valid is high, latch addr, funct3, write and wdata, then classify the request:
    - Error → RESP with misaligned=1:
      - halfword with addr[0]=1;
      - word with addr[1:0]≠0;
      - load funct3 ∈ {011,110,111};
      - store funct3 ∉ {000,001,010}.
    - Load → LOAD.
    - SW → WRITE, with merge register = wdata.
    - SB/SH → MERGE.
- **LOAD:**
  - mem_read=1.
  - Select the lane from mem_rdata by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes through.
  - Register the result into resp_rdata, then → RESP.
- **MERGE:**
  - mem_read=1.
  - Merge register = mem_rdata with the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
  - → WRITE.
- **WRITE:**
  - mem_write=1, mem_wdata = merge register.
  - Memory commits on this edge, then → RESP.
- **RESP:**
  - resp_valid=1 and req_ready=0.
  - → IDLE.
- **Memory-side outputs:**
  - mem_read, mem_write and mem_wdata are decoded from state.
  - mem_addr is the latched word address during LOAD/MERGE/WRITE and 0 otherwise.
  - mem_read and mem_write are never both high.
- **Response outputs:**
  - resp_rdata and resp_misaligned are registered and hold until the next accept.
  - On accept: resp_misaligned is loaded with the error result, and resp_rdata is cleared to 0 for stores and errors.
- **Reset:**
  - State → IDLE.
  - resp_valid, resp_rdata, resp_misaligned and the merge register are cleared to 0.
  - Reset mid-operation abandons the request with no response. mem_write is gated by !reset, so no partial write occurs.
- **Gating:** a request with req_valid high while req_ready=0 is ignored. Upstream holds it until accepted.

## Timing

- Accept is the cycle with req_valid & req_ready high; cycle N is the accept edge.
- Latency from accept edge to resp_valid high:
  - error: 1 cycle;
  - load: 2;
  - SW: 2;
  - SB/SH: 3.
- Throughput is one request per latency+1 cycles. IDLE is revisited between requests; there is no back-to-back pipelining.
- Memory read is combinational in the LOAD/MERGE cycle. The memory write lands at the end of the WRITE cycle, so a load issued after resp_valid observes the stored data.
- Reset takes effect at the first edge with reset=1. req_ready=1 in the cycle after reset deasserts.

## Test plan

- Preload word 0x10 = 0x8899AABB:
  - LB 0x11 → resp_rdata 0xFFFFFFAA.
  - LBU 0x11 → 0x000000AA.
  - LH 0x12 → 0xFFFF8899.
  - LW 0x10 → 0x8899AABB, resp_valid exactly 2 cycles after accept.
- SB 0x13, wdata 0x12345677 → MERGE→WRITE, word 0x10 = 0x7799AABB; resp_valid 3 cycles after accept; resp_rdata 0.
- SH 0x12, wdata 0x0000CAFE (word = 0x8899AABB) → word = 0xCAFEAABB. Then SW 0x10, 0xDEADBEEF → word = 0xDEADBEEF, with no mem_read cycle.
- Rejected requests → resp_misaligned=1 after 1 cycle, mem_read=mem_write=0 throughout, memory unchanged:
  - LW 0x12;
  - SH 0x11;
  - load funct3 = 011.
- Reset asserted during the WRITE state of SB 0x10 → mem_write low that cycle, word unchanged, no resp_valid, req_ready=1 after reset release.
- req_valid held high continuously with alternating LW/SW → each request accepted only in IDLE, exactly one resp_valid pulse per request, responses in order.
